// File: rtl/periph_bridge.sv
// periph_bridge: claims CPU data-memory accesses that fall in the peripheral
// address window, holds them on the peripheral bus until the target reports
// ready, and returns read data with a one-cycle acknowledge. A watchdog
// aborts accesses that never complete and flags a bus error.
module periph_bridge #(
    parameter logic [3:0]  PERIPH_REGION = 4'hF,
    parameter int unsigned TIMEOUT       = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    output logic [15:0] o_cpu_rdata,
    output logic        o_cpu_ack,
    output logic        o_cpu_err,
    output logic        o_cpu_busy,
    output logic [15:0] o_addr,
    output logic        o_sel,
    output logic        o_we,
    output logic        o_re,
    output logic [15:0] o_wdata,
    input  logic [15:0] i_rdata,
    input  logic        i_rdy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Counter value on which an access without ready is abandoned; checking
    // against TIMEOUT-1 places the abort exactly TIMEOUT cycles after o_sel rises.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_d, wdata_d, rdata_d;
    logic        sel_d, we_d, re_d, busy_d, ack_d, err_d;
    logic        in_window;

    assign in_window = (i_cpu_addr[15:12] == PERIPH_REGION);

    // Next-state and next-output logic; every bus/CPU output is registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = o_addr;
        wdata_d = o_wdata;
        rdata_d = o_cpu_rdata;
        sel_d   = o_sel;
        we_d    = o_we;
        re_d    = o_re;
        busy_d  = o_cpu_busy;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d  = 1'b0;
                we_d   = 1'b0;
                re_d   = 1'b0;
                busy_d = 1'b0;
                if (i_cpu_req && in_window) begin
                    addr_d  = i_cpu_addr;
                    wdata_d = i_cpu_wdata;
                    we_d    = i_cpu_we;
                    re_d    = !i_cpu_we;
                    sel_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (i_rdy) begin
                    rdata_d = o_we ? 16'h0000 : i_rdata;
                    ack_d   = 1'b1;
                    sel_d   = 1'b0;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rdata_d = 16'h0000;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    sel_d   = 1'b0;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered bus and CPU outputs; reset clears them all at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_addr      <= 16'h0000;
            o_wdata     <= 16'h0000;
            o_cpu_rdata <= 16'h0000;
            o_sel       <= 1'b0;
            o_we        <= 1'b0;
            o_re        <= 1'b0;
            o_cpu_busy  <= 1'b0;
            o_cpu_ack   <= 1'b0;
            o_cpu_err   <= 1'b0;
        end else begin
            o_addr      <= addr_d;
            o_wdata     <= wdata_d;
            o_cpu_rdata <= rdata_d;
            o_sel       <= sel_d;
            o_we        <= we_d;
            o_re        <= re_d;
            o_cpu_busy  <= busy_d;
            o_cpu_ack   <= ack_d;
            o_cpu_err   <= err_d;
        end
    end

endmodule
